// File: rtl/alert_scheduler_if.sv
// Alert scheduler bus: the four monitor request levels and the patient
// acknowledge going in, the shared alert output coming back.
//   master : drives req/ack, observes the alert outputs (monitors + patient side)
//   slave  : the scheduler itself
interface alert_scheduler_if;
  logic [3:0] req;           // [0] fall, [1] bpm, [2] temp, [3] medicine reminder
  logic       ack;           // patient acknowledge
  logic       alert_active;  // an alert is being presented
  logic [1:0] alert_id;      // presented source, valid while alert_active
  logic       buzzer;        // buzzer drive
  logic       escalate;      // current alert timed out without ack
  logic [3:0] pending;       // latched, not-yet-acknowledged requests

  modport master (
    output req, ack,
    input  alert_active, alert_id, buzzer, escalate, pending
  );

  modport slave (
    input  req, ack,
    output alert_active, alert_id, buzzer, escalate, pending
  );
endinterface

// File: rtl/alert_scheduler.sv
// Shares one patient-alert output between four monitors. Rising edges on the
// request lines are latched into pending bits; pending alerts are presented one
// at a time, lowest index first, with preemption by a higher-priority source.
// An acknowledge is accepted only after HOLD_CYCLES of presentation, and an
// alert left unacknowledged for TIMEOUT_CYCLES raises escalate.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : alert_scheduler_if.slave (req, ack in; alert_active, alert_id,
//            buzzer, escalate, pending out -- all outputs registered)
module alert_scheduler #(
  parameter int HOLD_CYCLES    = 4,  // min cycles shown before ack is accepted
  parameter int TIMEOUT_CYCLES = 8,  // cycles without accepted ack before escalate
  parameter int CW             = 8   // service counter width
) (
  input  logic                 clk,
  input  logic                 reset,
  alert_scheduler_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  state_t        state;
  logic [3:0]    pending;
  logic [3:0]    req_d;
  logic [CW-1:0] cnt;
  logic          alert_active;
  logic [1:0]    alert_id;
  logic          buzzer;
  logic          escalate;

  logic [3:0]    rise;
  logic [1:0]    win_id;
  logic [3:0]    above_mask;
  logic          preempt;
  logic          ack_ok;
  logic [CW-1:0] cnt_inc;

  assign rise = bus.req & ~req_d;

  // Lowest pending index wins; scanning from the top lets the lowest overwrite.
  // NOTE: every signal written in always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    win_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) win_id = 2'(i);
    end
  end

  // Sources with a smaller index than the one being served outrank it.
  assign above_mask = (4'b0001 << alert_id) - 4'b0001;
  assign preempt    = |(pending & above_mask);
  assign ack_ok     = bus.ack && (cnt >= CW'(HOLD_CYCLES));
  assign cnt_inc    = (cnt < CW'(TIMEOUT_CYCLES)) ? cnt + 1'b1 : cnt;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // right-hand side reads the pre-edge value; a later assignment to the same
  // register in this block overrides the earlier default.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 4'b0000;
      req_d        <= 4'b0000;
      cnt          <= '0;
      alert_active <= 1'b0;
      alert_id     <= 2'd0;
      buzzer       <= 1'b0;
      escalate     <= 1'b0;
    end else begin
      req_d   <= bus.req;
      // A new edge always wins over a clear in the same cycle.
      pending <= pending | rise;

      case (state)
        IDLE: begin
          if (|pending) begin
            state        <= SERVE;
            alert_id     <= win_id;
            cnt          <= '0;
            alert_active <= 1'b1;
            // cnt starts at 0, so the buzzer is on in the first cycle for every source.
            buzzer       <= 1'b1;
          end
        end

        SERVE: begin
          if (ack_ok) begin
            pending      <= (pending & ~(4'b0001 << alert_id)) | rise;
            escalate     <= 1'b0;
            state        <= GAP;
            alert_active <= 1'b0;
            buzzer       <= 1'b0;
          end else if (preempt) begin
            // The preempted alert keeps its pending bit and is served again later.
            escalate     <= 1'b0;
            state        <= GAP;
            alert_active <= 1'b0;
            buzzer       <= 1'b0;
          end else begin
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) escalate <= 1'b1;
            cnt    <= cnt_inc;
            // Fall/BPM buzz continuously; temp/medicine buzz on even counts.
            buzzer <= alert_id[1] ? ~cnt_inc[0] : 1'b1;
          end
        end

        GAP: begin
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          alert_active <= 1'b0;
          buzzer       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alert_active = alert_active;
  assign bus.alert_id     = alert_id;
  assign bus.buzzer       = buzzer;
  assign bus.escalate     = escalate;
  assign bus.pending      = pending;

endmodule

// File: tb/tb_alert_scheduler.sv
// Testbench for alert_scheduler: directed scenarios followed by randomized
// request/ack traffic, every cycle compared against a behavioural model.
module tb_alert_scheduler;

  localparam int HOLD = 4;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cur_req;
  logic       cur_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alert_scheduler_if bus ();
  assign bus.req = cur_req;
  assign bus.ack = cur_ack;

  alert_scheduler #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO),
    .CW             (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- behavioural model ----------------
  // Phases of service: 0 = waiting to arbitrate, 1 = presenting, 2 = gap.
  int m_phase;
  bit m_pend [4];
  bit m_prev [4];
  int m_id;
  int m_shown;      // cycles the current alert has been shown, capped at TO
  bit m_esc;

  task automatic model_reset();
    m_phase = 0;
    m_id    = 0;
    m_shown = 0;
    m_esc   = 0;
    for (int k = 0; k < 4; k++) begin
      m_pend[k] = 0;
      m_prev[k] = 0;
    end
  endtask

  function automatic int first_pending();
    for (int k = 0; k < 4; k++) if (m_pend[k]) return k;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic a);
    bit new_edge [4];
    int top;
    bit outranked;
    for (int k = 0; k < 4; k++) begin
      new_edge[k] = r[k] && !m_prev[k];
      m_prev[k]   = r[k];
    end
    top = first_pending();
    outranked = (top >= 0) && (top < m_id);
    if (m_phase == 0) begin
      if (top >= 0) begin
        m_phase = 1;
        m_id    = top;
        m_shown = 0;
      end
    end else if (m_phase == 1) begin
      if (a && m_shown >= HOLD) begin
        m_pend[m_id] = 0;
        m_esc   = 0;
        m_phase = 2;
      end else if (outranked) begin
        m_esc   = 0;
        m_phase = 2;
      end else begin
        if (m_shown == TO - 1) m_esc = 1;
        if (m_shown < TO) m_shown++;
      end
    end else begin
      m_phase = 0;
    end
    for (int k = 0; k < 4; k++) if (new_edge[k]) m_pend[k] = 1;
  endtask

  function automatic logic [3:0] model_pending();
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = m_pend[k];
    return p;
  endfunction

  function automatic logic model_buzzer();
    if (m_phase != 1) return 1'b0;
    if (m_id < 2) return 1'b1;
    return (m_shown % 2) == 0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("alert_active", 32'(bus.alert_active), 32'(m_phase == 1));
    if (m_phase == 1) check("alert_id", 32'(bus.alert_id), 32'(m_id));
    check("buzzer", 32'(bus.buzzer), 32'(model_buzzer()));
    check("escalate", 32'(bus.escalate), 32'(m_esc));
    check("pending", 32'(bus.pending), 32'(model_pending()));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cyc(input logic [3:0] r, input logic a);
    cur_req = r;
    cur_ack = a;
    @(posedge clk);
    model_step(r, a);
    #1;
    compare_all();
  endtask

  // Idle-ack until the model is presenting source id with shown count c.
  task automatic wait_serve(input string tag, input int id, input int c);
    int found = 0;
    for (int k = 0; k < 60; k++) begin
      if (m_phase == 1 && m_id == id && m_shown == c) begin
        found = 1;
        break;
      end
      cyc(cur_req, 1'b0);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_active", 32'(bus.alert_active), 32'd0);
    check("rst_id", 32'(bus.alert_id), 32'd0);
    check("rst_buzzer", 32'(bus.buzzer), 32'd0);
    check("rst_escalate", 32'(bus.escalate), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    cur_req = 4'b0000;
    cur_ack = 1'b0;
    model_reset();
    #12;
    apply_reset();
    repeat (3) cyc(4'b0000, 1'b0);

    // 1: temperature alert, ack at the first acceptable count.
    cyc(4'b0100, 1'b0);
    check("s1_pending_latched", 32'(bus.pending), 32'h4);
    cyc(4'b0100, 1'b0);
    check("s1_active", 32'(bus.alert_active), 32'd1);
    check("s1_id", 32'(bus.alert_id), 32'd2);
    cyc(4'b0100, 1'b0);
    check("s1_buzz_off_cnt1", 32'(bus.buzzer), 32'd0);
    wait_serve("s1_reach_hold", 2, HOLD);
    cyc(cur_req, 1'b1);
    check("s1_pending_cleared", 32'(bus.pending), 32'd0);
    check("s1_gap", 32'(bus.alert_active), 32'd0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // 2: medicine reminder, early ack ignored, later ack accepted.
    cyc(4'b1000, 1'b0);
    wait_serve("s2_cnt1", 3, 1);
    cyc(cur_req, 1'b1);
    check("s2_early_ack_ignored", 32'(bus.alert_active), 32'd1);
    wait_serve("s2_cnt5", 3, 5);
    check("s2_no_escalate", 32'(bus.escalate), 32'd0);
    cyc(cur_req, 1'b1);
    check("s2_accepted", 32'(bus.alert_active), 32'd0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // 3: BPM alert left alone until it escalates.
    cyc(4'b0010, 1'b0);
    wait_serve("s3_cnt7", 1, TO - 1);
    check("s3_not_yet", 32'(bus.escalate), 32'd0);
    cyc(cur_req, 1'b0);
    check("s3_escalate", 32'(bus.escalate), 32'd1);
    cyc(cur_req, 1'b0);
    check("s3_escalate_held", 32'(bus.escalate), 32'd1);
    cyc(cur_req, 1'b1);
    check("s3_escalate_clr", 32'(bus.escalate), 32'd0);
    check("s3_pending1_clr", 32'(bus.pending[1]), 32'd0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // 4: fall preempts a medicine alert, which is served again afterwards.
    cyc(4'b1000, 1'b0);
    wait_serve("s4_cnt2", 3, 2);
    cyc(4'b1001, 1'b0);
    cyc(4'b1001, 1'b0);
    check("s4_preempt_gap", 32'(bus.alert_active), 32'd0);
    check("s4_still_pending", 32'(bus.pending), 32'h9);
    wait_serve("s4_fall", 0, 1);
    check("s4_fall_buzz", 32'(bus.buzzer), 32'd1);
    wait_serve("s4_fall_hold", 0, HOLD);
    cyc(cur_req, 1'b1);
    wait_serve("s4_reserve", 3, 0);
    check("s4_reserve_id", 32'(bus.alert_id), 32'd3);
    wait_serve("s4_reserve_hold", 3, HOLD);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // 5: all four at once, served in priority order.
    cyc(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_serve("s5_order", i, HOLD);
      cyc(cur_req, 1'b1);
      check("s5_gap", 32'(bus.alert_active), 32'd0);
    end
    check("s5_all_done", 32'(bus.pending), 32'd0);
    cyc(4'b0000, 1'b0);

    // 6: reset mid-service with fall held high.
    cyc(4'b0001, 1'b0);
    wait_serve("s6_cnt2", 0, 2);
    apply_reset();
    cyc(4'b0001, 1'b0);
    check("s6_edge_after_reset", 32'(bus.pending), 32'h1);
    check("s6_not_active_yet", 32'(bus.alert_active), 32'd0);
    cyc(4'b0001, 1'b0);
    check("s6_active", 32'(bus.alert_active), 32'd1);
    cyc(4'b0000, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = cur_req;
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 999) == 0) apply_reset();
      cyc(r, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
